// File: rtl/me_feeder.sv
// me_feeder: sequences current-MB and search-window reads into the ME array and selects the best motion vector.
// Optional feature macro ME_ZERO_BIAS_EN: favours the zero-MV candidate by ZERO_BIAS in the compare.
module me_feeder #(
    parameter int MACRO_DIM   = 16,
    parameter int SEARCH_DIM  = 48,
    parameter int SAD_LATENCY = 3,
    parameter int ZERO_BIAS   = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          cpr_rd_en,
    output logic [$clog2(MACRO_DIM)-1:0]  cpr_rd_addr,
    input  logic [8*MACRO_DIM-1:0]        cpr_rd_data,
    output logic                          spr_rd_en,
    output logic [$clog2(SEARCH_DIM)-1:0] spr_rd_row,
    output logic [$clog2(SEARCH_DIM)-1:0] spr_rd_col,
    input  logic [8*MACRO_DIM-1:0]        spr_rd_data,
    output logic                          en_cpr,
    output logic                          en_spr,
    output logic [8*MACRO_DIM-1:0]        pixel_cpr_out,
    output logic [8*MACRO_DIM-1:0]        pixel_spr_out,
    input  logic [15:0]                   sad_in,
    output logic signed [7:0]             mv_x,
    output logic signed [7:0]             mv_y,
    output logic [15:0]                   best_sad,
    output logic                          mv_valid
);

    localparam int NC   = SEARCH_DIM - MACRO_DIM + 1;
    localparam int AW   = $clog2(MACRO_DIM);
    localparam int RW   = $clog2(SEARCH_DIM);
    localparam int DW   = (SAD_LATENCY > 1) ? $clog2(SAD_LATENCY) : 1;
    localparam int TL   = SAD_LATENCY - 1;
    localparam logic [RW-1:0] LOAD_LAST  = RW'(MACRO_DIM - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(SEARCH_DIM - 1);
    localparam logic [RW-1:0] COL_LAST   = RW'(NC - 1);
    localparam logic [RW-1:0] HALF       = RW'((NC - 1) / 2);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(SAD_LATENCY - 1);
    localparam logic signed [7:0] HALF_S = 8'((NC - 1) / 2);
    localparam logic [15:0]   ZB         = 16'(ZERO_BIAS);
`ifdef ME_ZERO_BIAS_EN
    localparam logic BIAS_EN = 1'b1;
`else
    localparam logic BIAS_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, SCAN, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [RW-1:0]      row_q, row_d, col_q, col_d;
    logic [DW-1:0]      dcnt_q, dcnt_d;
    logic               issue_vld, clear, done;
    logic               en_cpr_q, en_cpr_d, en_spr_q, en_spr_d;
    logic [TL:0]        tag_vld_q, tag_vld_d;
    logic [RW-1:0]      tag_x_q [SAD_LATENCY];
    logic [RW-1:0]      tag_x_d [SAD_LATENCY];
    logic [RW-1:0]      tag_y_q [SAD_LATENCY];
    logic [RW-1:0]      tag_y_d [SAD_LATENCY];
    logic               have_best_q, have_best_d;
    logic [15:0]        best_cmp_q, best_cmp_d, best_raw_q, best_raw_d;
    logic [RW-1:0]      best_x_q, best_x_d, best_y_q, best_y_d;
    logic [15:0]        cmp_sad;
    logic               zero_mv;
    logic signed [7:0]  mv_x_q, mv_x_d, mv_y_q, mv_y_d;
    logic [15:0]        best_sad_q, best_sad_d;
    logic               mv_valid_q, mv_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            dcnt_q      <= '0;
            en_cpr_q    <= 1'b0;
            en_spr_q    <= 1'b0;
            tag_vld_q   <= '0;
            for (int i = 0; i < SAD_LATENCY; i++) begin
                tag_x_q[i] <= '0;
                tag_y_q[i] <= '0;
            end
            have_best_q <= 1'b0;
            best_cmp_q  <= '0;
            best_raw_q  <= '0;
            best_x_q    <= '0;
            best_y_q    <= '0;
            mv_x_q      <= '0;
            mv_y_q      <= '0;
            best_sad_q  <= '0;
            mv_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            dcnt_q      <= dcnt_d;
            en_cpr_q    <= en_cpr_d;
            en_spr_q    <= en_spr_d;
            tag_vld_q   <= tag_vld_d;
            for (int i = 0; i < SAD_LATENCY; i++) begin
                tag_x_q[i] <= tag_x_d[i];
                tag_y_q[i] <= tag_y_d[i];
            end
            have_best_q <= have_best_d;
            best_cmp_q  <= best_cmp_d;
            best_raw_q  <= best_raw_d;
            best_x_q    <= best_x_d;
            best_y_q    <= best_y_d;
            mv_x_q      <= mv_x_d;
            mv_y_q      <= mv_y_d;
            best_sad_q  <= best_sad_d;
            mv_valid_q  <= mv_valid_d;
        end
    end

    // Sequencer: row is the inner loop during SCAN and doubles as the MB row during LOAD.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        dcnt_d    = dcnt_q;
        cpr_rd_en = 1'b0;
        spr_rd_en = 1'b0;
        issue_vld = 1'b0;
        clear     = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    row_d   = '0;
                    col_d   = '0;
                    clear   = 1'b1;
                end
            end
            LOAD: begin
                cpr_rd_en = 1'b1;
                if (row_q == LOAD_LAST) begin
                    row_d   = '0;
                    state_d = SCAN;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            SCAN: begin
                spr_rd_en = 1'b1;
                issue_vld = (row_q >= LOAD_LAST);
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        dcnt_d  = '0;
                        state_d = DRAIN;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            DRAIN: begin
                if (dcnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Candidate tags ride a SAD_LATENCY-deep pipe so they line up with the returning sad_in.
    always_comb begin
        en_cpr_d     = cpr_rd_en;
        en_spr_d     = spr_rd_en;
        tag_vld_d[0] = issue_vld && !clear;
        tag_x_d[0]   = col_q;
        tag_y_d[0]   = row_q - LOAD_LAST;
        for (int i = 1; i < SAD_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1] && !clear;
            tag_x_d[i]   = tag_x_q[i-1];
            tag_y_d[i]   = tag_y_q[i-1];
        end

        zero_mv = (tag_x_q[TL] == HALF) && (tag_y_q[TL] == HALF);
        cmp_sad = sad_in;
        if (BIAS_EN && zero_mv) begin
            cmp_sad = (sad_in > ZB) ? (sad_in - ZB) : '0;
        end

        have_best_d = have_best_q;
        best_cmp_d  = best_cmp_q;
        best_raw_d  = best_raw_q;
        best_x_d    = best_x_q;
        best_y_d    = best_y_q;
        if (clear) begin
            have_best_d = 1'b0;
            best_cmp_d  = '0;
            best_raw_d  = '0;
            best_x_d    = '0;
            best_y_d    = '0;
        end else if (tag_vld_q[TL] && (!have_best_q || cmp_sad < best_cmp_q)) begin
            have_best_d = 1'b1;
            best_cmp_d  = cmp_sad;
            best_raw_d  = sad_in;
            best_x_d    = tag_x_q[TL];
            best_y_d    = tag_y_q[TL];
        end

        mv_valid_d = done;
        mv_x_d     = mv_x_q;
        mv_y_d     = mv_y_q;
        best_sad_d = best_sad_q;
        if (clear) begin
            mv_x_d     = '0;
            mv_y_d     = '0;
            best_sad_d = '0;
        end else if (done) begin
            mv_x_d     = $signed(8'(best_x_q)) - HALF_S;
            mv_y_d     = $signed(8'(best_y_q)) - HALF_S;
            best_sad_d = best_raw_q;
        end
    end

    assign busy          = (state_q != IDLE) || mv_valid_q;
    assign cpr_rd_addr   = cpr_rd_en ? row_q[AW-1:0] : '0;
    assign spr_rd_row    = spr_rd_en ? row_q : '0;
    assign spr_rd_col    = spr_rd_en ? col_q : '0;
    assign en_cpr        = en_cpr_q;
    assign en_spr        = en_spr_q;
    assign pixel_cpr_out = en_cpr_q ? cpr_rd_data : '0;
    assign pixel_spr_out = en_spr_q ? spr_rd_data : '0;
    assign mv_x          = mv_x_q;
    assign mv_y          = mv_y_q;
    assign best_sad      = best_sad_q;
    assign mv_valid      = mv_valid_q;

endmodule

// File: tb/tb_me_feeder.sv
// Scoreboard bench for me_feeder: memory/SAD stubs, queued expectations, and a negedge monitor.
`timescale 1ns/1ps
module tb_me_feeder;

    localparam int MD = 16, SD = 48, NC = 33, LAT = 3, ZB = 64, HALF = 16, LATENCY = 1604;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic         busy, cpr_rd_en, spr_rd_en, en_cpr, en_spr, mv_valid;
    logic [3:0]   cpr_rd_addr;
    logic [5:0]   spr_rd_row, spr_rd_col;
    logic [127:0] cpr_rd_data, spr_rd_data, pixel_cpr_out, pixel_spr_out;
    logic [15:0]  sad_in, best_sad;
    logic signed [7:0] mv_x, mv_y;

    me_feeder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .cpr_rd_en(cpr_rd_en), .cpr_rd_addr(cpr_rd_addr), .cpr_rd_data(cpr_rd_data),
        .spr_rd_en(spr_rd_en), .spr_rd_row(spr_rd_row), .spr_rd_col(spr_rd_col),
        .spr_rd_data(spr_rd_data), .en_cpr(en_cpr), .en_spr(en_spr),
        .pixel_cpr_out(pixel_cpr_out), .pixel_spr_out(pixel_spr_out), .sad_in(sad_in),
        .mv_x(mv_x), .mv_y(mv_y), .best_sad(best_sad), .mv_valid(mv_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0, fails = 0, mv_seen = 0;

    logic [7:0] cur [MD][MD];
    logic [7:0] sw  [SD][SD];
    int         sad_tab [NC][NC];

    typedef struct {
        logic [7:0]  mx;
        logic [7:0]  my;
        logic [15:0] sad;
        int          st_edge;
    } res_t;

    logic [3:0]   q_cpr_addr [$];
    logic [11:0]  q_spr_addr [$];
    logic [127:0] q_cpr_pix  [$];
    logic [127:0] q_spr_pix  [$];
    res_t         q_res      [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] cur_row(input int r);
        logic [127:0] v;
        for (int i = 0; i < MD; i++) v[8*i +: 8] = cur[r][i];
        return v;
    endfunction

    function automatic logic [127:0] slice(input int r, input int c);
        logic [127:0] v;
        for (int i = 0; i < MD; i++) v[8*i +: 8] = (r < SD && c + i < SD) ? sw[r][c+i] : 8'h00;
        return v;
    endfunction

    // Reference: exhaustive argmin in scan order (x outer, y inner), strict improvement only.
    function automatic void model(output int bx, output int by, output int bs);
        int bc;
        bc = -1; bx = 0; by = 0; bs = 0;
        for (int x = 0; x < NC; x++) begin
            for (int y = 0; y < NC; y++) begin
                int v, c;
                v = sad_tab[x][y];
                c = v;
`ifdef ME_ZERO_BIAS_EN
                if (x == HALF && y == HALF) c = (v > ZB) ? v - ZB : 0;
`endif
                if (bc < 0 || c < bc) begin
                    bc = c; bx = x; by = y; bs = v;
                end
            end
        end
    endfunction

    // Line-memory and ME stubs: read data one cycle after the strobe, SAD LAT cycles after the issue.
    logic hv [LAT];
    int   hc [LAT];
    int   hr [LAT];
    initial begin
        logic ce, se;
        int   ca, sc, sr;
        forever begin
            @(negedge clk);
            ce = cpr_rd_en; ca = int'(cpr_rd_addr);
            se = spr_rd_en; sc = int'(spr_rd_col); sr = int'(spr_rd_row);
            for (int i = LAT - 1; i > 0; i--) begin
                hv[i] = hv[i-1]; hc[i] = hc[i-1]; hr[i] = hr[i-1];
            end
            hv[0] = se; hc[0] = sc; hr[0] = sr;
            @(posedge clk);
            #1;
            cpr_rd_data = ce ? cur_row(ca) : {$urandom, $urandom, $urandom, $urandom};
            spr_rd_data = se ? slice(sr, sc) : {$urandom, $urandom, $urandom, $urandom};
            if (hv[LAT-1] === 1'b1 && hr[LAT-1] >= MD - 1 && hr[LAT-1] - (MD - 1) < NC && hc[LAT-1] < NC)
                sad_in = 16'(sad_tab[hc[LAT-1]][hr[LAT-1] - (MD - 1)]);
            else
                sad_in = 16'($urandom);
        end
    end

    // Monitor: pops expectations whenever the DUT presents a strobe or a result.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (cpr_rd_en) begin
                if (q_cpr_addr.size() == 0) chk("cpr_rd_en_unexpected", cpr_rd_en, 1'b0);
                else chk("cpr_rd_addr", cpr_rd_addr, q_cpr_addr.pop_front());
            end
            if (spr_rd_en) begin
                if (q_spr_addr.size() == 0) chk("spr_rd_en_unexpected", spr_rd_en, 1'b0);
                else chk("spr_col_row", {spr_rd_col, spr_rd_row}, q_spr_addr.pop_front());
            end
            if (en_cpr) begin
                if (q_cpr_pix.size() == 0) chk("en_cpr_unexpected", en_cpr, 1'b0);
                else chk("pixel_cpr_out", pixel_cpr_out, q_cpr_pix.pop_front());
            end
            if (en_spr) begin
                chk("en_overlap", en_cpr, 1'b0);
                if (q_spr_pix.size() == 0) chk("en_spr_unexpected", en_spr, 1'b0);
                else chk("pixel_spr_out", pixel_spr_out, q_spr_pix.pop_front());
            end
            if (mv_valid) begin
                mv_seen++;
                if (q_res.size() == 0) chk("mv_valid_unexpected", mv_valid, 1'b0);
                else begin
                    res_t r;
                    r = q_res.pop_front();
                    chk("mv_x", {120'd0, mv_x}, {120'd0, r.mx});
                    chk("mv_y", {120'd0, mv_y}, {120'd0, r.my});
                    chk("best_sad", best_sad, r.sad);
                    chk("mv_latency", cyc - r.st_edge, LATENCY);
                    chk("busy_at_mv", busy, 1'b1);
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_cpr_rd_en"}, cpr_rd_en, 1'b0);
        chk({tag, "_spr_rd_en"}, spr_rd_en, 1'b0);
        chk({tag, "_addrs"}, {cpr_rd_addr, spr_rd_row, spr_rd_col}, 16'h0);
        chk({tag, "_en_cpr_spr"}, {en_cpr, en_spr}, 2'b00);
        chk({tag, "_pix_cpr"}, pixel_cpr_out, 128'h0);
        chk({tag, "_pix_spr"}, pixel_spr_out, 128'h0);
        chk({tag, "_mv"}, {mv_x, mv_y}, 16'h0);
        chk({tag, "_best_sad"}, best_sad, 16'h0);
        chk({tag, "_mv_valid"}, mv_valid, 1'b0);
    endtask

    task automatic flush_queues();
        q_cpr_addr.delete(); q_spr_addr.delete();
        q_cpr_pix.delete();  q_spr_pix.delete();
        q_res.delete();
    endtask

    // mode 0 random, 1 single minimum, 2 all ties, 3 zero-MV bias pattern.
    task automatic run(input int mode, input int poke_n, input int rst_n_at);
        int   bx, by, bs, seen0, n, st;
        res_t r;
        for (int a = 0; a < MD; a++) for (int b = 0; b < MD; b++) cur[a][b] = 8'($urandom);
        for (int a = 0; a < SD; a++) for (int b = 0; b < SD; b++) sw[a][b] = 8'($urandom);
        for (int x = 0; x < NC; x++) begin
            for (int y = 0; y < NC; y++) begin
                case (mode)
                    1:       sad_tab[x][y] = 100;
                    2:       sad_tab[x][y] = 0;
                    3:       sad_tab[x][y] = 50;
                    default: sad_tab[x][y] = int'($urandom_range(0, 4000));
                endcase
            end
        end
        if (mode == 1) sad_tab[20][5] = 7;
        if (mode == 3) sad_tab[HALF][HALF] = 100;
        model(bx, by, bs);

        seen0 = mv_seen;
        @(posedge clk);
        #2;
        st = cyc + 1;
        for (int a = 0; a < MD; a++) begin
            q_cpr_addr.push_back(4'(a));
            q_cpr_pix.push_back(cur_row(a));
        end
        for (int x = 0; x < NC; x++) begin
            for (int y = 0; y < SD; y++) begin
                q_spr_addr.push_back({6'(x), 6'(y)});
                q_spr_pix.push_back(slice(y, x));
            end
        end
        r.mx = 8'(bx - HALF); r.my = 8'(by - HALF); r.sad = 16'(bs); r.st_edge = st;
        q_res.push_back(r);
        start = 1'b1;

        for (int k = 0; k < 2000; k++) begin
            @(posedge clk);
            #2;
            n = cyc - st;
            start = (n == poke_n);
            if (n == 0) chk("busy_after_start", busy, 1'b1);
            if (n == rst_n_at) begin
                rst_n = 1'b0;
                #1;
                check_zero("abort");
                flush_queues();
                repeat (2) @(posedge clk);
                #2;
                rst_n = 1'b1;
                repeat (1700) @(posedge clk);
                #2;
                chk("abort_no_mv_valid", mv_seen - seen0, 0);
                chk("abort_busy", busy, 1'b0);
                return;
            end
            if (mv_seen != seen0) break;
        end
        start = 1'b0;
        chk("mv_valid_pulse_width", mv_valid, 1'b0);
        chk("busy_after_mv", busy, 1'b0);
        repeat (20) @(posedge clk);
        #2;
        chk("mv_count", mv_seen - seen0, 1);
        chk("busy_idle", busy, 1'b0);
        chk("best_sad_hold", best_sad, 16'(bs));
        chk("mv_hold", {mv_x, mv_y}, {r.mx, r.my});
        chk("cpr_queue_drained", q_cpr_addr.size() + q_cpr_pix.size(), 0);
        chk("spr_queue_drained", q_spr_addr.size() + q_spr_pix.size(), 0);
        chk("res_queue_drained", q_res.size(), 0);
        flush_queues();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        run(0, -1, -1);
        run(1, -1, -1);
        run(2, -1, -1);
        run(3, -1, -1);
        run(0, MD + 500, -1);
        run(0, -1, MD + 800);
        run(0, -1, -1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/me_feeder.md
Name: me_feeder

Overview:
- Drives the motion-estimation datapath for one macroblock search.
- Reads the 16x16 current macroblock and the 48x48 search window from line memories, then streams pixel rows with en_cpr/en_spr into the ME array.
- Consumes the returned per-candidate SAD stream and reports the best motion vector and its SAD.
- Sits between the frame-buffer readers and the ME array.

Parameters:
MACRO_DIM, 16, macroblock edge in pixels
SEARCH_DIM, 48, search window edge in pixels; candidates per axis NC = SEARCH_DIM-MACRO_DIM+1 (33)
SAD_LATENCY, 3, cycles from issuing an spr read to the matching sad being valid on sad_in
ZERO_BIAS, 64, SAD reduction applied to the zero-MV candidate (used only with ME_ZERO_BIAS_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a search; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until the mv_valid cycle, inclusive
cpr_rd_en  out  1  current-MB row read strobe
cpr_rd_addr  out  $clog2(MACRO_DIM)  current-MB row index
cpr_rd_data  in  8*MACRO_DIM  row data, valid 1 cycle after cpr_rd_en
spr_rd_en  out  1  search-window read strobe
spr_rd_row  out  $clog2(SEARCH_DIM)  search row index
spr_rd_col  out  $clog2(SEARCH_DIM)  leftmost column of the 16-pixel slice
spr_rd_data  in  8*MACRO_DIM  slice data, valid 1 cycle after spr_rd_en
en_cpr  out  1  to ME; pixel_cpr_out valid
en_spr  out  1  to ME; pixel_spr_out valid
pixel_cpr_out  out  8 x [0:MACRO_DIM-1]  current row to ME; byte i = bits 8i+7:8i
pixel_spr_out  out  8 x [0:MACRO_DIM-1]  search slice to ME
sad_in  in  16  SAD from ME
mv_x  out  8 signed  best horizontal offset, range -(NC-1)/2..+(NC-1)/2
mv_y  out  8 signed  best vertical offset
best_sad  out  16  raw SAD of the winning candidate
mv_valid  out  1  one-cycle pulse when the result is final

Behaviour:
- Reset: FSM=IDLE; all outputs 0; counters and best registers cleared. Reset mid-search aborts immediately. No mv_valid is produced for an aborted search.
- FSM states: IDLE -> LOAD -> SCAN -> DRAIN -> DONE -> IDLE.
- IDLE: on start=1, go to LOAD with row=0. start is ignored in all other states.
- LOAD: 16 cycles.
  - cpr_rd_en=1, cpr_rd_addr=0..15.
  - One cycle later: en_cpr=1 and pixel_cpr_out=cpr_rd_data (registered).
- SCAN: NC*SEARCH_DIM cycles (1584), no bubbles.
  - spr_rd_en=1; col x=0..NC-1 is the outer loop; row r=0..SEARCH_DIM-1 is the inner loop.
  - Row wraps 47->0 and col increments in the same cycle.
  - en_spr/pixel_spr_out follow the spr read by 1 cycle.
- Candidate tagging:
  - An issue with r>=MACRO_DIM-1 completes candidate (x, y=r-(MACRO_DIM-1)).
  - The tag {valid, x, y} enters a SAD_LATENCY-deep shift register; sad_in is sampled when the tag exits.
- Compare:
  - The first tagged sample loads best unconditionally.
  - After that, replace only if sad_in < best (strict). Ties keep the earlier candidate in scan order.
- DRAIN: SAD_LATENCY cycles, no reads issued. Remaining tags flush.
- DONE: 1 cycle.
  - mv_valid=1.
  - mv_x = x_best-(NC-1)/2 and mv_y = y_best-(NC-1)/2.
  - best_sad holds until the next accepted start.
- Timing: mv_valid occurs exactly 16+1584+SAD_LATENCY+1 = 1604 cycles after the start-sampling edge (default parameters).
- Result registers and best_sad are cleared to 0 on accepted start.
- The en_cpr and en_spr phases never overlap.

Optional Feature:
- ME_ZERO_BIAS_EN defined:
  - For candidate (x=(NC-1)/2, y=(NC-1)/2), the compare uses max(sad_in-ZERO_BIAS, 0) instead of sad_in.
  - best_sad still reports raw sad_in for that candidate.
- Undefined: all candidates are compared on raw sad_in; ZERO_BIAS is unused.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 asynchronously; FSM in IDLE; start pulse then completes normally.
- Uniform stub: sad_in=100 for all candidates except (x=20,y=5)=7 -> mv_x=+4, mv_y=-11, best_sad=7, mv_valid exactly 1604 cycles after start.
- Ties: sad_in=0 for every candidate -> mv=(-16,-16), best_sad=0 (first candidate wins).
- Address sequence: check cpr_rd_addr 0..15, then spr (col,row) (0,0)...(0,47),(1,0)...(32,47). en_cpr/en_spr lag by 1 with data passed through byte-exact.
- start asserted while busy at SCAN cycle 500 -> ignored, single mv_valid. Reset at SCAN cycle 800 -> no mv_valid, busy=0.
- ME_ZERO_BIAS_EN: sad_in=50 for all, zero-MV candidate=100 -> mv=(0,0), best_sad=100. Same stimulus without macro -> mv=(-16,-16), best_sad=50.
